// File: rtl/hex_display_pkg.sv
// Shared constants for the seven-segment display controller: register map,
// CTRL bit layout and reset value, and the active-low hex glyph table.
package hex_display_pkg;

  typedef enum logic [1:0] {
    REG_VALUE    = 2'd0,
    REG_CTRL     = 2'd1,
    REG_PRESCALE = 2'd2,
    REG_STATUS   = 2'd3
  } reg_addr_e;

  localparam int          CTRL_W       = 10;
  localparam int          CTRL_DISP_EN = 8;
  localparam int          CTRL_LZB     = 9;
  localparam logic [9:0]  CTRL_RST     = 10'h10F;

  localparam logic [6:0]  SEG_OFF      = 7'h7F;

  // Entry n is the {g,f,e,d,c,b,a} pattern for nibble n, active-low.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
    return GLYPH_TABLE[nibble];
  endfunction

endpackage

// File: rtl/hex7seg_decoder.sv
// Combinational nibble to seven-segment decoder, active-low outputs.
module hex7seg_decoder
  import hex_display_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = hex_glyph(i_nibble);

endmodule

// File: rtl/hex_display_ctrl.sv
// Memory-mapped four-digit seven-segment scan controller with a double-buffered
// value register. Optional leading-zero blanking is built when HEX_DISPLAY_LZB_EN is defined.
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int PRESCALE_RST = 25000,
  parameter int FRAME_W      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic [6:0]  hex,
  output logic        hex_dot,
  output logic [3:0]  hex_sel
);

  localparam logic [15:0] PRESCALE_RST_V = PRESCALE_RST[15:0];

  logic [15:0]        r_shadow;
  logic [15:0]        r_active;
  logic [CTRL_W-1:0]  r_ctrl;
  logic [15:0]        r_prescale;
  logic [15:0]        r_cnt;
  logic [1:0]         r_idx;
  logic [FRAME_W-1:0] r_frame;
  logic               r_live;

  logic               w_wr;
  logic               w_wr_value;
  logic               w_wr_ctrl;
  logic               w_wr_prescale;
  logic               w_tick;
  logic               w_wrap;
  logic [CTRL_W-1:0]  w_ctrl_wdata;
  logic [3:0]         w_nibble;
  logic [6:0]         w_seg;
  logic               w_lzb_blank;
  logic               w_digit_on;
  logic [3:0]         w_onehot;
  logic [31:0]        w_status;
  logic               w_unused;

  assign w_wr          = sel & we;
  assign w_wr_value    = w_wr & (addr == REG_VALUE);
  assign w_wr_ctrl     = w_wr & (addr == REG_CTRL);
  assign w_wr_prescale = w_wr & (addr == REG_PRESCALE);
  assign w_tick        = (r_cnt == 16'd0);
  assign w_wrap        = w_tick & (r_idx == 2'd3);
  assign w_unused      = ^wd[31:16];

`ifdef HEX_DISPLAY_LZB_EN
  assign w_ctrl_wdata = wd[9:0];
`else
  assign w_ctrl_wdata = {1'b0, wd[8:0]};
`endif

  // Bus-visible registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow   <= 16'd0;
      r_ctrl     <= CTRL_RST;
      r_prescale <= PRESCALE_RST_V;
    end else begin
      if (w_wr_value)    r_shadow   <= wd[15:0];
      if (w_wr_ctrl)     r_ctrl     <= w_ctrl_wdata;
      if (w_wr_prescale) r_prescale <= wd[15:0];
    end
  end

  // Scan timing, digit index, frame counter and the shadow-to-active transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= PRESCALE_RST_V;
      r_idx    <= 2'd0;
      r_frame  <= '0;
      r_active <= 16'd0;
      r_live   <= 1'b0;
    end else begin
      if (w_wr_prescale) begin
        r_cnt <= wd[15:0];
      end else if (w_tick) begin
        r_cnt <= r_prescale;
      end else begin
        r_cnt <= r_cnt - 16'd1;
      end
      if (w_tick) begin
        r_idx  <= r_idx + 2'd1;
        r_live <= 1'b1;
      end
      // A VALUE write coinciding with the wrap must not be lost for a whole frame.
      if (w_wrap) begin
        r_frame  <= r_frame + FRAME_W'(1);
        r_active <= w_wr_value ? wd[15:0] : r_shadow;
      end
    end
  end

  // Current digit nibble and leading-zero blanking
  always_comb begin
    w_nibble    = 4'd0;
    w_lzb_blank = 1'b0;
    case (r_idx)
      2'd0: w_nibble = r_active[3:0];
      2'd1: w_nibble = r_active[7:4];
      2'd2: w_nibble = r_active[11:8];
      2'd3: w_nibble = r_active[15:12];
      default: w_nibble = 4'd0;
    endcase
`ifdef HEX_DISPLAY_LZB_EN
    if (r_ctrl[CTRL_LZB]) begin
      case (r_idx)
        2'd1: w_lzb_blank = (r_active[15:4] == 12'd0);
        2'd2: w_lzb_blank = (r_active[15:8] == 8'd0);
        2'd3: w_lzb_blank = (r_active[15:12] == 4'd0);
        default: w_lzb_blank = 1'b0;
      endcase
    end else begin
      w_lzb_blank = 1'b0;
    end
`endif
  end

  hex7seg_decoder u_dec (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

  assign w_onehot   = 4'b0001 << r_idx;
  assign w_digit_on = r_ctrl[CTRL_DISP_EN] & r_ctrl[r_idx] & ~w_lzb_blank;

  // Pin registers; held dark until the scan has produced its first tick
  always_ff @(posedge clk) begin
    if (rst) begin
      hex     <= SEG_OFF;
      hex_dot <= 1'b1;
      hex_sel <= 4'hF;
    end else if (!r_live) begin
      hex     <= SEG_OFF;
      hex_dot <= 1'b1;
      hex_sel <= 4'hF;
    end else begin
      hex     <= w_seg;
      hex_dot <= ~r_ctrl[4 + r_idx];
      hex_sel <= w_digit_on ? ~w_onehot : 4'hF;
    end
  end

  // Read mux
  always_comb begin
    w_status                  = 32'd0;
    w_status[1:0]             = r_idx;
    w_status[8 +: FRAME_W]    = r_frame;
    rd                        = 32'd0;
    if (sel) begin
      case (addr)
        REG_VALUE:    rd = {16'd0, r_shadow};
        REG_CTRL:     rd = {{(32-CTRL_W){1'b0}}, r_ctrl};
        REG_PRESCALE: rd = {16'd0, r_prescale};
        REG_STATUS:   rd = w_status;
        default:      rd = 32'd0;
      endcase
    end else begin
      rd = 32'd0;
    end
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench for hex_display_ctrl: directed scenarios plus random bus
// traffic, all compared cycle by cycle against a behavioural model of the display.
module tb_hex_display_ctrl;

  localparam int P_RST = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wd = 32'd0;
  logic [31:0] rd;
  logic [6:0]  hex;
  logic        hex_dot;
  logic [3:0]  hex_sel;

  int n_checks = 0;
  int n_fail = 0;

  hex_display_ctrl #(.PRESCALE_RST(P_RST), .FRAME_W(8)) dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr), .wd(wd),
    .rd(rd), .hex(hex), .hex_dot(hex_dot), .hex_sel(hex_sel)
  );

  always #5 clk = ~clk;

  logic [6:0] gly [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

`ifdef HEX_DISPLAY_LZB_EN
  localparam int CMASK = 32'h3FF;
`else
  localparam int CMASK = 32'h1FF;
`endif

  int   m_cnt, m_idx, m_frame, m_shadow, m_active, m_ctrl, m_pre;
  bit   m_live;
  logic [6:0] e_hex;
  logic       e_dot;
  logic [3:0] e_sel;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = P_RST; m_idx = 0; m_frame = 0; m_shadow = 0; m_active = 0;
    m_ctrl = 32'h10F; m_pre = P_RST; m_live = 0;
    e_hex = 7'h7F; e_dot = 1'b1; e_sel = 4'hF;
  endtask

  function automatic logic [31:0] model_rd();
    if (!sel) return 32'd0;
    case (addr)
      2'd0: return m_shadow;
      2'd1: return m_ctrl;
      2'd2: return m_pre;
      default: return m_idx | (m_frame << 8);
    endcase
  endfunction

  // Advance the model across one rising edge with the inputs currently applied.
  task automatic model_edge();
    bit tick, on;
    int nib;
    if (rst) begin
      model_reset();
      return;
    end
    if (!m_live) begin
      e_hex = 7'h7F; e_dot = 1'b1; e_sel = 4'hF;
    end else begin
      nib   = (m_active >> (4 * m_idx)) & 15;
      e_hex = gly[nib];
      e_dot = !((m_ctrl >> (4 + m_idx)) & 1);
      on    = ((m_ctrl >> 8) & 1) && ((m_ctrl >> m_idx) & 1);
`ifdef HEX_DISPLAY_LZB_EN
      if (((m_ctrl >> 9) & 1) && m_idx > 0 && (m_active >> (4 * m_idx)) == 0) on = 0;
`endif
      e_sel = on ? 4'(~(1 << m_idx)) : 4'hF;
    end
    tick = (m_cnt == 0);
    if (tick) begin
      if (m_idx == 3) begin
        m_frame  = (m_frame + 1) % 256;
        m_active = (sel && we && addr == 2'd0) ? (wd & 32'hFFFF) : m_shadow;
      end
      m_idx  = (m_idx + 1) % 4;
      m_live = 1;
    end
    if (sel && we && addr == 2'd2) m_cnt = wd & 32'hFFFF;
    else if (tick) m_cnt = m_pre;
    else m_cnt = m_cnt - 1;
    if (sel && we) begin
      case (addr)
        2'd0: m_shadow = wd & 32'hFFFF;
        2'd1: m_ctrl = wd & CMASK;
        2'd2: m_pre = wd & 32'hFFFF;
        default: ;
      endcase
    end
  endtask

  // One clock: apply inputs at the falling edge, check rd, then the pins after the edge.
  task automatic cyc(input logic s, input logic w, input logic [1:0] a, input logic [31:0] d);
    sel = s; we = w; addr = a; wd = d;
    #1;
    check("rd", rd, model_rd());
    @(posedge clk);
    model_edge();
    #1;
    check("hex", {25'd0, hex}, {25'd0, e_hex});
    check("hex_dot", {31'd0, hex_dot}, {31'd0, e_dot});
    check("hex_sel", {28'd0, hex_sel}, {28'd0, e_sel});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 2'($urandom_range(0, 3)), 32'd0);
  endtask

  task automatic wait_sel(input logic [3:0] pat, input string tag);
    int k;
    k = 0;
    while (hex_sel !== pat && k < 64) begin
      idle(1);
      k++;
    end
    if (k == 64) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Count slot occupancy over n cycles and check the glyph in each driven slot.
  task automatic slot_scan(input int n, input logic [6:0] g0, input logic [6:0] g1,
                           input logic [6:0] g2, input logic [6:0] g3,
                           output int c0, output int c1, output int c2, output int c3);
    c0 = 0; c1 = 0; c2 = 0; c3 = 0;
    for (int i = 0; i < n; i++) begin
      idle(1);
      case (hex_sel)
        4'b1110: begin c0++; check("slot0_glyph", {25'd0, hex}, {25'd0, g0}); end
        4'b1101: begin c1++; check("slot1_glyph", {25'd0, hex}, {25'd0, g1}); end
        4'b1011: begin c2++; check("slot2_glyph", {25'd0, hex}, {25'd0, g2}); end
        4'b0111: begin c3++; check("slot3_glyph", {25'd0, hex}, {25'd0, g3}); end
        default: ;
      endcase
    end
  endtask

  initial begin
    int c0, c1, c2, c3, f0, f1, lat;
    logic [31:0] d;
    logic [1:0]  a;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    cyc(1'b1, 1'b0, 2'd1, 32'd0);
    check("rst_ctrl", rd, 32'h10F);

    // Latency of the first driven digit after reset release.
    rst = 1'b0;
    lat = 0;
    while (hex_sel === 4'hF && lat < 40) begin
      idle(1);
      lat++;
    end
    check("first_digit_lat", lat, P_RST + 2);

    // Basic frame: PRESCALE=3, VALUE=0x1A2F.
    cyc(1'b1, 1'b1, 2'd2, 32'd3);
    cyc(1'b1, 1'b1, 2'd0, 32'hFFFF_1A2F);
    cyc(1'b1, 1'b0, 2'd0, 32'd0);
    check("value_rb", rd, 32'h1A2F);
    idle(40);
    slot_scan(16, 7'h0E, 7'h24, 7'h08, 7'h79, c0, c1, c2, c3);
    check("slot0_len", c0, 4);
    check("slot1_len", c1, 4);
    check("slot2_len", c2, 4);
    check("slot3_len", c3, 4);

    // VALUE write mid-frame only lands after the wrap.
    wait_sel(4'b1101, "slot1");
    cyc(1'b1, 1'b1, 2'd0, 32'h8888);
    wait_sel(4'b1110, "slot0_after");
    check("new_value_digit0", {25'd0, hex}, 32'h00);
    idle(8);

    // Dot mask on digit 1 only.
    cyc(1'b1, 1'b1, 2'd1, 32'h12F);
    idle(2);
    for (int i = 0; i < 16; i++) begin
      idle(1);
      check("dot_mask", {31'd0, hex_dot}, (e_sel == 4'b1101) ? 32'd0 : 32'd1);
    end

    // Display disabled: pins dark, scan keeps running.
    cyc(1'b1, 1'b1, 2'd1, 32'h00F);
    idle(2);
    cyc(1'b1, 1'b0, 2'd3, 32'd0);
    f0 = rd[1:0];
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 2'd3, 32'd0);
    check("disabled_sel", {28'd0, hex_sel}, 32'hF);
    check("idx_advances", rd[1:0], (f0 + 1) % 4);

`ifdef HEX_DISPLAY_LZB_EN
    cyc(1'b1, 1'b1, 2'd1, 32'h30F);
    cyc(1'b1, 1'b1, 2'd0, 32'h0005);
    idle(36);
    slot_scan(16, 7'h12, 7'h7F, 7'h7F, 7'h7F, c0, c1, c2, c3);
    check("lzb_slot0_len", c0, 4);
    check("lzb_others", c1 + c2 + c3, 0);
`endif

    // Random bus traffic against the model.
    for (int i = 0; i < 400; i++) begin
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      if (a == 2'd2) d = $urandom_range(0, 4);
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d);
    end

    // PRESCALE=0: one tick per cycle, 260 frames wrap the 8-bit counter.
    cyc(1'b1, 1'b1, 2'd2, 32'd0);
    cyc(1'b1, 1'b0, 2'd3, 32'd0);
    f0 = rd[15:8];
    for (int i = 0; i < 1040; i++) cyc(1'b1, 1'b0, 2'd3, 32'd0);
    f1 = rd[15:8];
    check("frame_260", (f1 - f0) & 255, 4);

    // Reset mid-frame.
    cyc(1'b1, 1'b1, 2'd1, 32'h1FF);
    idle(3);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 2'd0, 32'd0);
    check("rst_hex", {25'd0, hex}, 32'h7F);
    check("rst_dot", {31'd0, hex_dot}, 32'd1);
    check("rst_sel", {28'd0, hex_sel}, 32'hF);
    rst = 1'b0;
    cyc(1'b1, 1'b0, 2'd3, 32'd0);
    check("rst_status", rd, 32'd0);
    idle(12);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hex_display_ctrl.md
# hex_display_ctrl

Memory-mapped four-digit seven-segment display controller, downstream of the core's data memory. The `memory` address decoder forwards store and load cycles in the display window to this block. It holds the value to show and its display controls, time-multiplexes the four digits, and drives the board's `hex`, `hex_dot` and `hex_sel` pins. Value updates are double-buffered so a frame never shows a mix of old and new digits.

## Interface
Parameters:
- `PRESCALE_RST`, default 25000: reset value of the PRESCALE register (cycles per digit slot minus 1).
- `FRAME_W`, default 8: width of the frame counter.

Ports:
- `clk`  in  1  system clock; only clock.
- `rst`  in  1  reset. Synchronous, active-high.
- `sel`  in  1  chip select from the memory decoder.
- `we`  in  1  write strobe; a write happens only when `sel & we`.
- `addr`  in  2  word index within the window.
- `wd`  in  32  write data.
- `rd`  out  32  read data. Combinational from `addr`; 0 when `sel`=0.
- `hex`  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- `hex_dot`  out  1  decimal point, active-low, registered.
- `hex_sel`  out  4  digit anodes, active-low, registered; bit 0 is the rightmost digit.

## Operation
Register map (by `addr`):
- 0 VALUE, R/W. Bits [15:0] go to the shadow register; reads return the shadow. Bits [31:16] are ignored and read 0.
- 1 CTRL, R/W, reset 0x10F.
  - [3:0] per-digit enable.
  - [7:4] dot mask.
  - [8] display enable.
  - [9] leading-zero blank (only when the macro is enabled).
  - Other bits read 0.
- 2 PRESCALE, R/W, bits [15:0], reset `PRESCALE_RST`.
- 3 STATUS, read-only: [1:0] current digit index; [8+FRAME_W-1:8] frame counter. Writes are ignored.

Scan behaviour:
- A 16-bit down-counter reloads from PRESCALE when it reaches 0. That reload cycle is a "tick".
- Each tick advances the digit index 0→1→2→3→0.
- On the 3→0 advance (frame wrap):
  - the shadow register copies into the active register;
  - the frame counter increments, wrapping modulo 2^FRAME_W.
- The digit shown is `active[4*i+3:4*i]` for digit index i, decoded to standard hex glyphs (0–F).

Output rules for digit slot i:
- `hex_sel` = ~(onehot(i)) when CTRL[8] and CTRL[i] are set; 4'hF otherwise.
- `hex_dot` = ~CTRL[4+i].
- Scanning continues while the display is disabled.

Boundary cases:
- PRESCALE=0: a tick every cycle.
- A write to PRESCALE reloads the counter with the new value on the next cycle.
- A VALUE write in the same cycle as a frame wrap: the active register takes `wd[15:0]` directly (bypass), and the shadow also takes it.
- `rst` mid-frame returns everything to reset state within one cycle.

## Timing
Reset values:
- `hex`=7'h7F, `hex_dot`=1, `hex_sel`=4'hF.
- Digit index 0, counter=PRESCALE_RST, VALUE shadow and active = 0, frame counter = 0.

Latency:
- Output registers update one cycle after a tick, showing the new digit index.
- The first digit is driven PRESCALE_RST+2 cycles after `rst` deasserts.
- A register write is visible on `rd` the next cycle.
- A CTRL change affects the outputs on the next cycle; it does not wait for a tick.
- A VALUE change reaches the pins only after the next frame wrap.

## Configuration
- `HEX_DISPLAY_LZB_EN` defined:
  - CTRL[9] is implemented and resets to 0.
  - When CTRL[9]=1, digits 3..1 whose nibble and every higher nibble of the active value are 0 are blanked (`hex_sel` bit high).
  - Digit 0 is never blanked.
- Not defined: CTRL[9] reads 0, writes to it are ignored, and there is no blanking logic.

## Structure
- Package `hex_display_pkg` holds:
  - register offsets, CTRL bit positions and reset value;
  - the segment-off constant 7'h7F;
  - the 16-entry glyph table.
- One sub-module, `hex7seg_decoder`: combinational nibble → `hex[6:0]`, active-low.
- Scan counter, registers and bus logic stay in `hex_display_ctrl`.

## Test plan
1. Reset; write PRESCALE=3, VALUE=0x1A2F; wait one frame.
   - Expect `hex_sel` cycling 1110, 1101, 1011, 0111, four cycles each.
   - Expect `hex` = 0x0E, 0x24, 0x08, 0x79 in those slots.
2. With 0x1A2F displayed, write VALUE=0x8888 during digit slot 1.
   - Digits 2 and 3 still show 0x24's neighbours (0x08, 0x79).
   - From the next digit 0 onward, `hex` = 0x00.
3. Write CTRL=0x12F (dot mask 0x2) → `hex_dot`=0 only while `hex_sel`=1101.
4. Write CTRL=0x00F → `hex_sel`=4'hF from the next cycle. STATUS[1:0] keeps advancing.
5. With the macro enabled: write CTRL=0x30F, VALUE=0x0005; after the wrap:
   - only slot 0 drives (`hex_sel`=1110, `hex`=0x12);
   - the other slots are 1111.
6. Run 260 frames with PRESCALE=0 → STATUS frame counter = 4 (260 mod 256). Assert `rst` mid-frame → all outputs return to reset values on the next cycle.
